// File: rtl/multi_key_debouncer.sv
// N-channel key debouncer: 2-FF synchroniser, registered polarity compare, stable-time filter,
// one-cycle press/release strobes. Auto-repeat is built only when MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module multi_key_debouncer #(
    parameter int CHANNELS             = 4,
    parameter int CLK_FREQ_MHZ         = 150,
    parameter int GLITCH_TIME_NS       = 10,
    parameter int ACTIVE_LOW           = 1,
    parameter int REPEAT_DELAY_CYCLES  = 1000,
    parameter int REPEAT_PERIOD_CYCLES = 250
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] key_state_o,
    output logic [CHANNELS-1:0] key_pressed_stb_o,
    output logic [CHANNELS-1:0] key_released_stb_o,
    output logic [CHANNELS-1:0] key_repeat_stb_o
);

    localparam int LIMIT_RAW = (CLK_FREQ_MHZ * GLITCH_TIME_NS + 999) / 1000;
    localparam int LIMIT     = (LIMIT_RAW < 1) ? 1 : LIMIT_RAW;
    localparam int CNT_W     = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);
    // Pin level of a released key; the synchroniser resets to it so reset release is silent.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_e;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             sync1_q, sync2_q, raw_q;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             state_q, state_d;
            logic             press_q, press_d;
            logic             rel_q, rel_d;

            always_comb begin
                cnt_d   = cnt_q;
                state_d = state_q;
                press_d = 1'b0;
                rel_d   = 1'b0;
                if (raw_q == state_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = raw_q;
                    cnt_d   = '0;
                    press_d = raw_q;
                    rel_d   = ~raw_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync1_q <= IDLE_LVL;
                    sync2_q <= IDLE_LVL;
                    raw_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= 1'b0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    sync1_q <= key_i[gi];
                    sync2_q <= sync1_q;
                    raw_q   <= (sync2_q != IDLE_LVL);
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                    press_q <= press_d;
                    rel_q   <= rel_d;
                end
            end

            assign key_state_o[gi]        = state_q;
            assign key_pressed_stb_o[gi]  = press_q;
            assign key_released_stb_o[gi] = rel_q;

`ifdef MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN
            rep_state_e    rstate_q, rstate_d;
            logic [RW-1:0] rcnt_q, rcnt_d;
            logic          rep_q, rep_d;

            // Driven by the same-edge press/release events so the FSM lines up with the strobes.
            always_comb begin
                rstate_d = rstate_q;
                rcnt_d   = rcnt_q;
                rep_d    = 1'b0;
                case (rstate_q)
                    R_IDLE: begin
                        if (press_d) begin
                            rstate_d = R_DELAY;
                            rcnt_d   = '0;
                        end
                    end
                    R_DELAY: begin
                        if (rel_d) begin
                            rstate_d = R_IDLE;
                            rcnt_d   = '0;
                        end else if (rcnt_q == DELAY_MAX) begin
                            rstate_d = R_REPEAT;
                            rcnt_d   = '0;
                            rep_d    = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    R_REPEAT: begin
                        if (rel_d) begin
                            rstate_d = R_IDLE;
                            rcnt_d   = '0;
                        end else if (rcnt_q == PERIOD_MAX) begin
                            rcnt_d = '0;
                            rep_d  = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        rstate_d = R_IDLE;
                        rcnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rstate_q <= R_IDLE;
                    rcnt_q   <= '0;
                    rep_q    <= 1'b0;
                end else begin
                    rstate_q <= rstate_d;
                    rcnt_q   <= rcnt_d;
                    rep_q    <= rep_d;
                end
            end

            assign key_repeat_stb_o[gi] = rep_q;
`else
            assign key_repeat_stb_o[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: doc/multi_key_debouncer.md
# multi_key_debouncer

Parametrised N-channel key debouncer: each channel synchronises a raw mechanical key input, filters glitches shorter than a configurable time, and reports a clean held level plus one-cycle press and release strobes. It sits between board key pins and user logic (menus, counters, FSMs). Keys are independent; one shared timing configuration applies to all channels. An optional auto-repeat engine generates periodic strobes while a key is held.

## Interface
- CHANNELS, 4, number of independent keys (1..32)
- CLK_FREQ_MHZ, 150, clock frequency in MHz
- GLITCH_TIME_NS, 10, minimum stable time before a level change is accepted
- ACTIVE_LOW, 1, 1: key pressed when pin is 0; 0: pressed when pin is 1
- REPEAT_DELAY_CYCLES, 1000, cycles from press strobe to first repeat strobe (auto-repeat only)
- REPEAT_PERIOD_CYCLES, 250, cycles between subsequent repeat strobes (auto-repeat only)
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous reset, active-low
- key_i  input  CHANNELS  raw asynchronous key pins
- key_state_o  output  CHANNELS  debounced level, 1 = pressed
- key_pressed_stb_o  output  CHANNELS  one-cycle pulse on accepted press
- key_released_stb_o  output  CHANNELS  one-cycle pulse on accepted release
- key_repeat_stb_o  output  CHANNELS  one-cycle pulse per auto-repeat event (0 when feature compiled out)

## Operation
- LIMIT = max(1, ceil(CLK_FREQ_MHZ*GLITCH_TIME_NS/1000)); counter width $clog2(LIMIT+1).
- Per channel: 2-FF synchroniser; raw_pressed = sync XOR ACTIVE_LOW-inverted, i.e. pressed = (sync == !ACTIVE_LOW).
- Stable register state (drives key_state_o). Counter cnt counts consecutive cycles with raw_pressed != state.
- raw_pressed == state: cnt <= 0.
- raw_pressed != state and cnt < LIMIT-1: cnt <= cnt+1.
- raw_pressed != state and cnt == LIMIT-1: state <= raw_pressed, cnt <= 0, assert press strobe (new state 1) or release strobe (new state 0) on the same edge.
- A disagreement shorter than LIMIT cycles restarts cnt at 0; no output change.
- Channels never interact; simultaneous events on several channels produce simultaneous independent strobes.
- Press and release strobe of one channel are never high together.

## Timing
- Reset (rst_ni low, asynchronous): synchroniser FFs load the released pin level (1 if ACTIVE_LOW else 0), cnt = 0, state = 0, all strobes 0, repeat FSM IDLE. No strobe after reset release if pins idle.
- Reset asserted mid-count or mid-repeat aborts everything immediately; a key held through reset release is reported as a fresh press after 2+LIMIT cycles.
- Latency: pin change sampled at edge 0 -> key_state_o and strobe high after edge LIMIT+2.
- Strobes are registered, exactly one cycle wide.
- Auto-repeat FSM per channel: IDLE -> DELAY on press strobe (rcnt=0); DELAY -> REPEAT when rcnt reaches REPEAT_DELAY_CYCLES-1, pulsing key_repeat_stb_o, rcnt=0; REPEAT pulses every REPEAT_PERIOD_CYCLES; any state -> IDLE on release strobe cycle, no repeat pulse on that cycle.
- First repeat pulse occurs REPEAT_DELAY_CYCLES cycles after the press strobe; later ones REPEAT_PERIOD_CYCLES apart.

## Configuration
- Macro MULTI_KEY_DEBOUNCER_AUTOREPEAT_EN.
- Defined: repeat FSM and counters per channel are built; key_repeat_stb_o as specified.
- Undefined: no repeat logic synthesised; key_repeat_stb_o tied to 0; REPEAT_* parameters ignored.

## Test plan
- CLK_FREQ_MHZ=100, GLITCH_TIME_NS=50 (LIMIT=5), ACTIVE_LOW=1: key_i[0] 1->0 held -> key_pressed_stb_o[0] one cycle and key_state_o[0]=1 after edge 7; other channels silent.
- Same config: key_i[1] low for 4 synchronised cycles then high -> no strobe, key_state_o[1] stays 0; low for 5 -> press accepted.
- Bouncing press (0/1 toggle every 2 cycles for 20 cycles, then stable 0) -> exactly one press strobe, 7 cycles after last bounce.
- Release after hold -> single key_released_stb_o, key_state_o falls same cycle; channels 0 and 3 released same cycle -> both strobes same cycle.
- Autorepeat on, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8, hold 50 cycles after press strobe -> repeat pulses at +20, +28, +36, +44, +52 ignored after release; none after release strobe.
- rst_ni pulsed low during counting and during REPEAT with key held -> all outputs 0 immediately; press re-reported 7 cycles after reset release.
